alu_pipe: RTL and testbench

- Parametrised, registered successor to the team's 4-bit combinational ALU (add/sub, compare, AND).
- Generalised to WIDTH bits with an 8-entry opcode set: add, sub, compare, and, or, xor, accumulate and accumulator load.
- Adds a persistent accumulator, result flags, and valid/ready handshakes on both sides, so it can sit between a sequencer/operand source and a downstream consumer that may stall.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_core.sv | 86 ++++++++
 rtl/alu_pipe.sv | 133 +++++++++++++
 tb/tb_alu_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcode encodings, flag-vector indices and pipeline state
//             type for the registered ALU (alu_core / alu_pipe).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // 3-bit opcode set
  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_CMP     = 3'b010;
  localparam logic [2:0] OP_AND     = 3'b011;
  localparam logic [2:0] OP_OR      = 3'b100;
  localparam logic [2:0] OP_XOR     = 3'b101;
  localparam logic [2:0] OP_ACC_ADD = 3'b110;
  localparam logic [2:0] OP_ACC_LD  = 3'b111;

  // Positions of the compare flags inside the flag vector
  localparam int FLAG_LT = 0;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_GT = 2;
  localparam int FLAG_W  = 3;

  // Output-register occupancy
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } pipe_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Purpose  : Purely combinational ALU datapath. Computes the candidate
//             result, carry/borrow, compare flags and accumulator update for
//             one operation; alu_pipe decides whether to commit them.
//  Ports    : op          in   opcode (alu_pkg OP_*)
//             a, b        in   unsigned operands
//             acc         in   accumulator base value (already clear-adjusted)
//             next_result out  candidate result
//             next_carry  out  carry (ADD/ACC_ADD) or borrow (SUB), else 0
//             next_acc    out  candidate accumulator value
//             acc_we      out  op writes the accumulator
//             flags       out  {gt, eq, lt} indexed by FLAG_*
//  Revision : 1.0  initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  acc,
  output logic [WIDTH-1:0]  next_result,
  output logic              next_carry,
  output logic [WIDTH-1:0]  next_acc,
  output logic              acc_we,
  output logic [FLAG_W-1:0] flags
);

  // One extra bit captures carry-out; for the subtraction the top bit is the
  // borrow, which equals (a < b) for unsigned operands.
  logic [WIDTH:0] sum_ab;
  logic [WIDTH:0] diff_ab;
  logic [WIDTH:0] sum_acc;

  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign diff_ab = {1'b0, a} - {1'b0, b};
  assign sum_acc = {1'b0, acc} + {1'b0, a};

  always_comb begin
    next_result = '0;
    next_carry  = 1'b0;
    next_acc    = acc;
    acc_we      = 1'b0;
    case (op)
      OP_ADD: begin
        next_result = sum_ab[WIDTH-1:0];
        next_carry  = sum_ab[WIDTH];
      end
      OP_SUB: begin
        next_result = diff_ab[WIDTH-1:0];
        next_carry  = diff_ab[WIDTH];
      end
      OP_CMP: begin
        next_result = '0;
      end
      OP_AND: next_result = a & b;
      OP_OR:  next_result = a | b;
      OP_XOR: next_result = a ^ b;
      OP_ACC_ADD: begin
        next_result = sum_acc[WIDTH-1:0];
        next_carry  = sum_acc[WIDTH];
        next_acc    = sum_acc[WIDTH-1:0];
        acc_we      = 1'b1;
      end
      OP_ACC_LD: begin
        next_result = a;
        next_acc    = a;
        acc_we      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    flags          = '0;
    flags[FLAG_GT] = (a > b);
    flags[FLAG_EQ] = (a == b);
    flags[FLAG_LT] = (a < b);
  end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : One-stage registered ALU with valid/ready handshakes on both
//             sides, a persistent accumulator and result/compare flags.
//  Ports    : clk, rst_n         clock, asynchronous active-low reset
//             in_valid/in_ready  operand-side handshake
//             op, a, b           opcode and unsigned operands
//             acc_clr            accumulator clear (acts every cycle)
//             out_valid/out_ready result-side handshake
//             result, carry      registered result and carry/borrow
//             a_gt_b/a_eq_b/a_lt_b  registered compare flags
//             zero               registered result==0
//             acc                current accumulator value
//  Revision : 1.0  initial release
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  pipe_state_t       state_q;
  pipe_state_t       state_d;
  logic              accept;
  logic              consume;

  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  acc_base;
  logic [WIDTH-1:0]  result_q;
  logic              carry_q;
  logic [FLAG_W-1:0] flags_q;
  logic              zero_q;

  logic [WIDTH-1:0]  core_result;
  logic              core_carry;
  logic [WIDTH-1:0]  core_acc;
  logic              core_acc_we;
  logic [FLAG_W-1:0] core_flags;

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // Clearing in the same cycle as an ACC_ADD makes the add start from
  // ACC_INIT, so the clear is folded into the value handed to the core.
  assign acc_base = acc_clr ? ACC_INIT : acc_q;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op          (op),
    .a           (a),
    .b           (b),
    .acc         (acc_base),
    .next_result (core_result),
    .next_carry  (core_carry),
    .next_acc    (core_acc),
    .acc_we      (core_acc_we),
    .flags       (core_flags)
  );

  // Occupancy FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)       state_d = ST_FULL;
        else if (consume) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output registers load only on accept, so a stall holds them unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      flags_q  <= '0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      result_q <= core_result;
      carry_q  <= core_carry;
      flags_q  <= core_flags;
      zero_q   <= (core_result == '0);
    end
  end

  // Accumulator: an accepted ACC op wins; otherwise acc_base already carries
  // any pending clear (and equals acc_q when there is none).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       acc_q <= ACC_INIT;
    else if (accept && core_acc_we)   acc_q <= core_acc;
    else                              acc_q <= acc_base;
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign a_gt_b = flags_q[FLAG_GT];
  assign a_eq_b = flags_q[FLAG_EQ];
  assign a_lt_b = flags_q[FLAG_LT];
  assign zero   = zero_q;
  assign acc    = acc_q;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe
//  Purpose  : Directed checks of a WIDTH=4 alu_pipe plus a randomised
//             WIDTH=8 run against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=4 instance
  logic       in_valid, in_ready, acc_clr, out_valid, out_ready;
  logic [2:0] op;
  logic [3:0] a, b, result, acc;
  logic       carry, a_gt_b, a_eq_b, a_lt_b, zero;

  // WIDTH=8 instance, ACC_INIT=8'h5A
  logic       w8_in_valid, w8_in_ready, w8_acc_clr, w8_out_valid, w8_out_ready;
  logic [2:0] w8_op;
  logic [7:0] w8_a, w8_b, w8_result, w8_acc;
  logic       w8_carry, w8_gt, w8_eq, w8_lt, w8_zero;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(4), .ACC_INIT(4'h0)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry(carry), .a_gt_b(a_gt_b),
    .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .zero(zero), .acc(acc)
  );

  alu_pipe #(.WIDTH(8), .ACC_INIT(8'h5A)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .op(w8_op), .a(w8_a), .b(w8_b), .acc_clr(w8_acc_clr),
    .out_valid(w8_out_valid), .out_ready(w8_out_ready), .result(w8_result),
    .carry(w8_carry), .a_gt_b(w8_gt), .a_eq_b(w8_eq), .a_lt_b(w8_lt),
    .zero(w8_zero), .acc(w8_acc)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compares {out_valid, result, carry, gt, eq, lt, zero} of the 4-bit DUT.
  task automatic check_out(input string tag, input logic ev, input logic [3:0] er,
                           input logic ec, input logic [2:0] ef, input logic ez);
    chk(tag, 16'({out_valid, result, carry, a_gt_b, a_eq_b, a_lt_b, zero}),
             16'({ev, er, ec, ef, ez}));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [3:0] aa,
                       input logic [3:0] bb);
    in_valid = v;
    op       = o;
    a        = aa;
    b        = bb;
  endtask

  // Reference model state for the WIDTH=8 run
  logic       m_valid;
  logic [7:0] m_res, m_acc, acc_base, r;
  logic       m_c, m_z, c;
  logic [2:0] m_f;
  logic [8:0] wide;
  logic       v, rdy, clr, acc_ok, cons;
  logic [2:0] o;
  logic [7:0] aa, bb;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    acc_clr = 1'b0; out_ready = 1'b1;
    w8_in_valid = 1'b0; w8_op = 3'b000; w8_a = 8'h00; w8_b = 8'h00;
    w8_acc_clr = 1'b0; w8_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_out", 1'b0, 4'h0, 1'b0, 3'b000, 1'b0);
    chk("reset_acc", 16'(acc), 16'h0);
    chk("reset_in_ready", 16'(in_ready), 16'h1);
    chk("reset_acc_w8", 16'(w8_acc), 16'h5A);
    rst_n = 1'b1;

    // Basic ops, one per cycle
    drive(1'b1, OP_AND, 4'b0101, 4'b1001); tick;
    check_out("and", 1'b1, 4'b0001, 1'b0, 3'b001, 1'b0);
    drive(1'b1, OP_ADD, 4'b1101, 4'b0101); tick;
    check_out("add", 1'b1, 4'b0010, 1'b1, 3'b100, 1'b0);
    drive(1'b1, OP_SUB, 4'b0011, 4'b0101); tick;
    check_out("sub", 1'b1, 4'b1110, 1'b1, 3'b001, 1'b0);
    drive(1'b1, OP_OR, 4'b0101, 4'b1001); tick;
    check_out("or", 1'b1, 4'b1101, 1'b0, 3'b001, 1'b0);
    drive(1'b1, OP_CMP, 4'b0110, 4'b0110); tick;
    check_out("cmp", 1'b1, 4'b0000, 1'b0, 3'b010, 1'b1);

    // Stall with the XOR queued at the input
    out_ready = 1'b0;
    drive(1'b1, OP_XOR, 4'b1111, 4'b1010);
    #1;
    chk("stall_in_ready", 16'(in_ready), 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check_out("stall_hold", 1'b1, 4'b0000, 1'b0, 3'b010, 1'b1);
      chk("stall_in_ready_hold", 16'(in_ready), 16'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 16'(in_ready), 16'h1);
    tick;
    check_out("xor", 1'b1, 4'b0101, 1'b0, 3'b100, 1'b0);
    drive(1'b0, OP_ADD, 4'h0, 4'h0); tick;
    chk("drain_valid", 16'(out_valid), 16'h0);

    // Accumulator
    drive(1'b1, OP_ACC_LD, 4'b0011, 4'b0000); tick;
    check_out("acc_ld", 1'b1, 4'b0011, 1'b0, 3'b100, 1'b0);
    chk("acc_ld_acc", 16'(acc), 16'h3);
    drive(1'b1, OP_ACC_ADD, 4'b0100, 4'b0100); tick;
    check_out("acc_add1", 1'b1, 4'b0111, 1'b0, 3'b010, 1'b0);
    chk("acc_add1_acc", 16'(acc), 16'h7);
    drive(1'b1, OP_ACC_ADD, 4'b1010, 4'b0000); tick;
    check_out("acc_add2", 1'b1, 4'b0001, 1'b1, 3'b100, 1'b0);
    chk("acc_add2_acc", 16'(acc), 16'h1);
    acc_clr = 1'b1;
    drive(1'b1, OP_ACC_ADD, 4'b0010, 4'b0010); tick;
    check_out("clr_acc_add", 1'b1, 4'b0010, 1'b0, 3'b010, 1'b0);
    chk("clr_acc_add_acc", 16'(acc), 16'h2);
    drive(1'b1, OP_ACC_LD, 4'b1001, 4'b0000); tick;
    check_out("clr_acc_ld", 1'b1, 4'b1001, 1'b0, 3'b100, 1'b0);
    chk("clr_acc_ld_acc", 16'(acc), 16'h9);
    acc_clr = 1'b0;
    drive(1'b1, OP_ADD, 4'b0001, 4'b0001); tick;
    check_out("add_keeps_acc", 1'b1, 4'b0010, 1'b0, 3'b010, 1'b0);
    chk("add_keeps_acc_acc", 16'(acc), 16'h9);

    // acc_clr during a stall
    out_ready = 1'b0; acc_clr = 1'b1;
    drive(1'b0, OP_ACC_LD, 4'hF, 4'h0); tick;
    acc_clr = 1'b0;
    chk("clr_stall_acc", 16'(acc), 16'h0);
    check_out("clr_stall_hold", 1'b1, 4'b0010, 1'b0, 3'b010, 1'b0);
    out_ready = 1'b1; tick;
    chk("clr_stall_drain", 16'(out_valid), 16'h0);

    // Asynchronous reset while FULL and stalled
    drive(1'b1, OP_ACC_LD, 4'b0101, 4'b0000); tick;
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 4'b0001, 4'b0001); tick;
    check_out("pre_rst_hold", 1'b1, 4'b0101, 1'b0, 3'b100, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_out("async_rst_out", 1'b0, 4'h0, 1'b0, 3'b000, 1'b0);
    chk("async_rst_acc", 16'(acc), 16'h0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 4'b0011, 4'b0100); tick;
    check_out("post_rst_add", 1'b1, 4'b0111, 1'b0, 3'b001, 1'b0);
    drive(1'b0, OP_ADD, 4'h0, 4'h0); tick;

    // WIDTH=8 randomised run against a behavioural model
    m_valid = 1'b0; m_res = '0; m_c = 1'b0; m_f = '0; m_z = 1'b0; m_acc = 8'h5A;
    for (int i = 0; i < 400; i++) begin
      chk("w8_valid", 16'(w8_out_valid), 16'(m_valid));
      if (m_valid) begin
        chk("w8_out", 16'({w8_result, w8_carry, w8_gt, w8_eq, w8_lt, w8_zero}),
                      16'({m_res, m_c, m_f, m_z}));
        chk("w8_onehot", 16'($onehot({w8_gt, w8_eq, w8_lt})), 16'h1);
      end
      chk("w8_acc", 16'(w8_acc), 16'(m_acc));

      v   = ($urandom_range(0, 3) != 0);
      o   = 3'($urandom_range(0, 7));
      aa  = 8'($urandom_range(0, 255));
      bb  = 8'($urandom_range(0, 255));
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 9) == 0);
      w8_in_valid = v; w8_op = o; w8_a = aa; w8_b = bb;
      w8_out_ready = rdy; w8_acc_clr = clr;
      #1;
      chk("w8_in_ready", 16'(w8_in_ready), 16'(!m_valid || rdy));

      acc_base = clr ? 8'h5A : m_acc;
      acc_ok   = v && (!m_valid || rdy);
      cons     = m_valid && rdy;
      if (acc_ok) begin
        c = 1'b0;
        case (o)
          OP_ADD:     begin wide = {1'b0, aa} + {1'b0, bb}; r = wide[7:0]; c = wide[8]; end
          OP_SUB:     begin r = aa - bb; c = (aa < bb); end
          OP_CMP:     r = 8'h00;
          OP_AND:     r = aa & bb;
          OP_OR:      r = aa | bb;
          OP_XOR:     r = aa ^ bb;
          OP_ACC_ADD: begin wide = {1'b0, acc_base} + {1'b0, aa}; r = wide[7:0]; c = wide[8]; end
          default:    r = aa;
        endcase
        if (o == OP_ACC_ADD || o == OP_ACC_LD) m_acc = r;
        else                                   m_acc = acc_base;
        m_res = r; m_c = c; m_z = (r == 8'h00);
        m_f = {aa > bb, aa == bb, aa < bb};
        m_valid = 1'b1;
      end else begin
        m_acc = acc_base;
        if (cons) m_valid = 1'b0;
      end
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_pipe
`default_nettype wire
